// File: rtl/lbm_pkg.sv
// Shared lattice types, default lattice size and the collision sequencer state encoding.
package lbm_pkg;
  localparam int LBM_LATTICE_W = 64;
  localparam int LBM_LATTICE_H = 48;

  typedef logic [8:0][7:0] cell_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } seq_state_t;
endpackage

// File: rtl/addr_fifo.sv
// Synchronous show-ahead FIFO: head is visible while not empty.
// Push when full and pop when empty are ignored.
module addr_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_dat,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW:0]      r_wptr;
  logic [PW:0]      r_rptr;

  // The extra pointer bit separates full from empty when the indices match.
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
  assign o_head  = r_mem[r_rptr[PW-1:0]];

  always_ff @(posedge i_clk) begin
    if (i_push && !o_full) begin
      r_mem[r_wptr[PW-1:0]] <= i_push_dat;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (i_push && !o_full) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (i_pop && !o_empty) begin
        r_rptr <= r_rptr + 1'b1;
      end
    end
  end
endmodule

// File: rtl/collision_sequencer.sv
// One collision sweep: read cells from BRAM, stream to collision, write results back in order.
// Define BOUNDARY_SKIP_EN to leave the outer ring of cells to the boundary stage.
module collision_sequencer
  import lbm_pkg::*;
#(
  parameter int LATTICE_W       = LBM_LATTICE_W,
  parameter int LATTICE_H       = LBM_LATTICE_H,
  parameter int BRAM_LATENCY    = 2,
  parameter int MAX_OUTSTANDING = 32,
  parameter int ADDR_WIDTH      = $clog2(LATTICE_W * LATTICE_H)
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  start_in,
  output logic                  busy_out,
  output logic                  done_out,
  output logic                  rd_en_out,
  output logic [ADDR_WIDTH-1:0] rd_addr_out,
  input  cell_t                 rd_data_in,
  output cell_t                 col_data_out,
  output logic                  col_valid_out,
  input  cell_t                 col_data_in,
  input  logic                  col_done_in,
  output logic                  wr_en_out,
  output logic [ADDR_WIDTH-1:0] wr_addr_out,
  output cell_t                 wr_data_out,
  output logic                  error_out
);
  localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
`ifdef BOUNDARY_SKIP_EN
  localparam int X_FIRST = 1;
  localparam int X_LAST  = LATTICE_W - 2;
  localparam int Y_FIRST = 1;
  localparam int Y_LAST  = LATTICE_H - 2;
`else
  localparam int X_FIRST = 0;
  localparam int X_LAST  = LATTICE_W - 1;
  localparam int Y_FIRST = 0;
  localparam int Y_LAST  = LATTICE_H - 1;
`endif
  localparam int ROW_STEP   = LATTICE_W - X_LAST + X_FIRST;
  localparam int FIRST_ADDR = Y_FIRST * LATTICE_W + X_FIRST;

  seq_state_t r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr, r_x, r_y;
  logic [OW-1:0] r_outst;
  logic [BRAM_LATENCY-1:0] r_vline;
  logic r_done, r_col_vld, r_wr_en, r_err;
  cell_t r_col_dat, r_wr_dat;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic w_issue, w_pop, w_last, w_start, w_done_nxt;
  logic w_fifo_full, w_fifo_empty;
  logic [ADDR_WIDTH-1:0] w_head;

  assign w_last = (r_x == ADDR_WIDTH'(X_LAST)) && (r_y == ADDR_WIDTH'(Y_LAST));
  // Results with nothing in flight are stale and must not pop or write.
  assign w_pop  = col_done_in && (r_outst != '0) && !w_fifo_empty;

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_start     = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start_in) begin
          w_start     = 1'b1;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if ((r_outst < OW'(MAX_OUTSTANDING)) && !w_fifo_full) begin
          w_issue = 1'b1;
          if (w_last) w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (r_outst == '0) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_outst   <= '0;
      r_vline   <= '0;
      r_done    <= 1'b0;
      r_col_vld <= 1'b0;
      r_col_dat <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_dat  <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
      if (w_start) begin
        r_addr <= ADDR_WIDTH'(FIRST_ADDR);
        r_x    <= ADDR_WIDTH'(X_FIRST);
        r_y    <= ADDR_WIDTH'(Y_FIRST);
      end else if (w_issue && !w_last) begin
        if (r_x == ADDR_WIDTH'(X_LAST)) begin
          r_x    <= ADDR_WIDTH'(X_FIRST);
          r_y    <= r_y + 1'b1;
          r_addr <= r_addr + ADDR_WIDTH'(ROW_STEP);
        end else begin
          r_x    <= r_x + 1'b1;
          r_addr <= r_addr + 1'b1;
        end
      end
      case ({w_issue, w_pop})
        2'b10:   r_outst <= r_outst + 1'b1;
        2'b01:   r_outst <= r_outst - 1'b1;
        default: r_outst <= r_outst;
      endcase
      r_vline[0] <= w_issue;
      for (int i = 1; i < BRAM_LATENCY; i++) begin
        r_vline[i] <= r_vline[i-1];
      end
      r_col_vld <= r_vline[BRAM_LATENCY-1];
      if (r_vline[BRAM_LATENCY-1]) r_col_dat <= rd_data_in;
      r_wr_en <= w_pop;
      if (w_pop) begin
        r_wr_addr <= w_head;
        r_wr_dat  <= col_data_in;
      end
      if (col_done_in && (r_outst == '0)) r_err <= 1'b1;
    end
  end

  addr_fifo #(
    .WIDTH (ADDR_WIDTH),
    .DEPTH (MAX_OUTSTANDING)
  ) u_addr_fifo (
    .i_clk      (clk_in),
    .i_rst_n    (rst_in),
    .i_push     (w_issue),
    .i_push_dat (r_addr),
    .i_pop      (w_pop),
    .o_head     (w_head),
    .o_full     (w_fifo_full),
    .o_empty    (w_fifo_empty)
  );

  assign busy_out      = (r_state != IDLE);
  assign done_out      = r_done;
  assign rd_en_out     = w_issue;
  assign rd_addr_out   = r_addr;
  assign col_data_out  = r_col_dat;
  assign col_valid_out = r_col_vld;
  assign wr_en_out     = r_wr_en;
  assign wr_addr_out   = r_wr_addr;
  assign wr_data_out   = r_wr_dat;
  assign error_out     = r_err;
endmodule

// File: tb/tb_collision_sequencer.sv
// Bench for collision_sequencer: BRAM and collision models, in-order write scoreboard, sweep table.
module tb_collision_sequencer;
  import lbm_pkg::*;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int BL = 2;
  localparam int MO = 8;
  localparam int AW = $clog2(W * H);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0, start = 1'b0;
  logic busy, done, rd_en, col_valid, col_done = 1'b0, wr_en, err;
  logic [AW-1:0] rd_addr, wr_addr;
  cell_t rd_data = '0, col_data_o, col_data_i = '0, wr_data;

  collision_sequencer #(
    .LATTICE_W(W), .LATTICE_H(H), .BRAM_LATENCY(BL), .MAX_OUTSTANDING(MO), .ADDR_WIDTH(AW)
  ) dut (
    .clk_in(clk), .rst_in(rst_n), .start_in(start), .busy_out(busy), .done_out(done),
    .rd_en_out(rd_en), .rd_addr_out(rd_addr), .rd_data_in(rd_data),
    .col_data_out(col_data_o), .col_valid_out(col_valid), .col_data_in(col_data_i),
    .col_done_in(col_done), .wr_en_out(wr_en), .wr_addr_out(wr_addr), .wr_data_out(wr_data),
    .error_out(err)
  );

  typedef struct { int due; cell_t d; } cq_t;
  typedef struct { logic [AW-1:0] a; cell_t d; } wq_t;
  typedef struct { string tag; int lat; bit mid; int exp_max; int exp_span; } vec_t;

  int tests = 0, fails = 0;
  int cyc = 0, lat = 1;
  int exp_addr[$];
  cell_t mem [W*H];
  logic [AW-1:0] rd_pipe [BL+1];
  logic rd_vpipe [BL+1];
  cq_t coll_q[$];
  wq_t exp_wr_q[$];
  int iss_q[$];
  cell_t col_q[$];
  int rd_idx = 0, sw_rd = 0, sw_cd = 0, sw_wr = 0, n_wr = 0, n_donep = 0;
  int max_inf = 0, inflight = 0, first_rd = -1, last_rd = -1, first_cd = -1, rd_mo_cyc = -1;
  logic [AW-1:0] mon_a;
  wq_t mon_w;
  cq_t mon_c;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic cell_t plus1(input cell_t c);
    cell_t r;
    for (int i = 0; i < 9; i++) r[i] = c[i] + 8'd1;
    return r;
  endfunction

  always @(posedge clk) cyc++;

  // BRAM read model, collision model and write scoreboard, all sampled mid-cycle.
  always @(negedge clk) begin
    for (int i = BL; i > 0; i--) begin
      rd_pipe[i]  = rd_pipe[i-1];
      rd_vpipe[i] = rd_vpipe[i-1];
    end
    rd_pipe[0]  = rd_addr;
    rd_vpipe[0] = rd_en;
    rd_data = rd_vpipe[BL] ? mem[rd_pipe[BL]] : {$urandom, $urandom, 8'($urandom)};

    if (rd_en) begin
      sw_rd++;
      if (first_rd < 0) first_rd = cyc;
      last_rd = cyc;
      if (sw_rd == MO + 1) rd_mo_cyc = cyc;
      check("rd_in_range", rd_idx < exp_addr.size(), 1);
      if (rd_idx < exp_addr.size()) begin
        mon_a = AW'(exp_addr[rd_idx]);
        check("rd_addr", rd_addr, mon_a);
        iss_q.push_back(cyc);
        col_q.push_back(mem[mon_a]);
        exp_wr_q.push_back('{mon_a, plus1(mem[mon_a])});
        rd_idx++;
      end
    end

    if (col_valid) begin
      check("col_expected", iss_q.size() > 0, 1);
      if (iss_q.size() > 0) begin
        check("col_latency", cyc - iss_q.pop_front(), BL + 1);
        check("col_data", col_data_o, col_q.pop_front());
      end
      coll_q.push_back('{cyc + lat, plus1(col_data_o)});
    end

    col_done = 1'b0;
    if (coll_q.size() > 0 && coll_q[0].due <= cyc) begin
      mon_c = coll_q.pop_front();
      col_done   = 1'b1;
      col_data_i = mon_c.d;
      sw_cd++;
      if (first_cd < 0) first_cd = cyc;
    end

    if (wr_en) begin
      sw_wr++;
      n_wr++;
      check("wr_expected", exp_wr_q.size() > 0, 1);
      if (exp_wr_q.size() > 0) begin
        mon_w = exp_wr_q.pop_front();
        check("wr_addr", wr_addr, mon_w.a);
        check("wr_data", wr_data, mon_w.d);
        mem[mon_w.a] = mon_w.d;
      end
    end

    if (done) begin
      n_donep++;
      check("busy_at_done", busy, 0);
    end

    inflight = sw_rd - sw_cd;
    if (inflight > max_inf) max_inf = inflight;

    if (!rst_n) begin
      iss_q.delete();
      col_q.delete();
      exp_wr_q.delete();
      rd_idx = 0;
    end
  end

  task automatic run_sweep(input string tag, input int l, input bit mid, input int exp_max, input int exp_span);
    int nd0;
    int n;
    n = exp_addr.size();
    @(posedge clk); #1;
    lat = l; rd_idx = 0; sw_rd = 0; sw_cd = 0; sw_wr = 0; max_inf = 0;
    first_rd = -1; last_rd = -1; first_cd = -1; rd_mo_cyc = -1;
    nd0 = n_donep;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check({tag, "_busy_hi"}, busy, 1);
    for (int k = 0; k < 3000 && n_donep == nd0; k++) begin
      @(negedge clk);
      start = (mid && k == 3);
    end
    start = 1'b0;
    repeat (4) @(negedge clk);
    check({tag, "_writes"}, sw_wr, n);
    check({tag, "_reads"}, rd_idx, n);
    check({tag, "_done_cnt"}, n_donep - nd0, 1);
    check({tag, "_err"}, err, 0);
    check({tag, "_busy_lo"}, busy, 0);
    check({tag, "_sb_empty"}, exp_wr_q.size(), 0);
    check({tag, "_inflight_le"}, max_inf <= MO, 1);
    if (exp_max >= 0) check({tag, "_inflight_max"}, max_inf, exp_max);
    if (exp_span >= 0) check({tag, "_rd_span"}, last_rd - first_rd, exp_span);
    if (l >= 20 && n > MO) check({tag, "_stall"}, rd_mo_cyc > first_cd, 1);
  endtask

  vec_t vecs[4];
  int n_cells, wr_mark;

  initial begin
    for (int i = 0; i <= BL; i++) begin
      rd_pipe[i]  = '0;
      rd_vpipe[i] = 1'b0;
    end
    for (int i = 0; i < W * H; i++) mem[i] = {$urandom, $urandom, 8'($urandom)};
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
`ifdef BOUNDARY_SKIP_EN
        if (x > 0 && x < W - 1 && y > 0 && y < H - 1) exp_addr.push_back(y * W + x);
`else
        exp_addr.push_back(y * W + x);
`endif
      end
    n_cells = exp_addr.size();

    vecs[0] = '{"lat1",      1, 1'b0, -1, n_cells - 1};
    vecs[1] = '{"lat20",    20, 1'b0, (n_cells < MO) ? n_cells : MO, -1};
    vecs[2] = '{"lat20_mid",20, 1'b1, (n_cells < MO) ? n_cells : MO, -1};
    vecs[3] = '{"lat3_mid",  3, 1'b1, -1, n_cells - 1};

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_col_valid", col_valid, 0);
    check("rst_col_data", col_data_o, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_error", err, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 4; v++) run_sweep(vecs[v].tag, vecs[v].lat, vecs[v].mid, vecs[v].exp_max, vecs[v].exp_span);

    // Result returned while idle: no write, sticky error.
    wr_mark = n_wr;
    @(posedge clk); #1;
    coll_q.push_back('{cyc + 1, '0});
    repeat (4) @(negedge clk);
    check("idle_done_no_wr", n_wr - wr_mark, 0);
    check("idle_done_err", err, 1);
    repeat (10) @(negedge clk);
    check("idle_err_sticky", err, 1);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_err_cleared", err, 0);

    // Reset mid-sweep: stale results must be dropped and flagged.
    @(posedge clk); #1;
    lat = 20; rd_idx = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wr_mark = n_wr;
    @(negedge clk);
    check("midrst_err_cleared", err, 0);
    check("midrst_busy", busy, 0);
    check("midrst_stale_pending", coll_q.size() > 0, 1);
    for (int k = 0; k < 300 && coll_q.size() > 0; k++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("midrst_stale_drained", coll_q.size(), 0);
    check("midrst_no_wr", n_wr - wr_mark, 0);
    check("midrst_stale_err", err, 1);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("fresh_err_cleared", err, 0);
    run_sweep("fresh", 20, 1'b0, (n_cells < MO) ? n_cells : MO, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end
endmodule
